// File: rtl/dm_pkg.sv
// Shared types and elaboration helpers for the dual-slave descriptor memory.
package dm_pkg;

    typedef enum logic {
        PORT_S1 = 1'b0,
        PORT_S2 = 1'b1
    } port_t;

    // One entry of the read-valid pipeline: which slave owns the read and whether it was out of range.
    typedef struct packed {
        logic v_s1;
        logic v_s2;
        logic oor;
    } rd_tag_t;

    function automatic int unsigned rd_latency(input int unsigned out_reg);
        return 32'(1 + out_reg);
    endfunction

    function automatic bit params_legal(input int unsigned data_w,
                                        input int unsigned depth,
                                        input int unsigned addr_w);
        return (data_w != 0) && ((data_w % 8) == 0) && (depth != 0) &&
               (64'(depth) <= (64'(1) << addr_w));
    endfunction

endpackage

// File: rtl/dm_ram_be.sv
// Inferred single-port byte-enabled RAM; no reset so it maps onto block RAM.
module dm_ram_be
    import dm_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned OUT_REG = 0,
    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned NB     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [NB-1:0]     i_be,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < int'(NB); b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                    end
                end
            end else begin
                r_q <= r_mem[i_addr];
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_W-1:0] r_q2;
        always_ff @(posedge clk) begin
            r_q2 <= r_q;
        end
        assign o_rdata = r_q2;
    end else begin : g_noreg
        assign o_rdata = r_q;
    end

endmodule

// File: rtl/descriptor_memory_dp.sv
// Two Avalon-MM slaves (CPU on s1, SG-DMA on s2) sharing one byte-enabled descriptor RAM
// through a round-robin arbiter with pipelined, tagged read returns.
module descriptor_memory_dp
    import dm_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned OUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic [ADDR_W-1:0]     s1_address,
    input  logic                  s1_chipselect,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    input  logic [DATA_W-1:0]     s1_writedata,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,
    output logic                  s1_waitrequest,

    input  logic [ADDR_W-1:0]     s2_address,
    input  logic                  s2_chipselect,
    input  logic                  s2_read,
    input  logic                  s2_write,
    input  logic [DATA_W/8-1:0]   s2_byteenable,
    input  logic [DATA_W-1:0]     s2_writedata,
    output logic [DATA_W-1:0]     s2_readdata,
    output logic                  s2_readdatavalid,
    output logic                  s2_waitrequest
);

    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned LAT    = rd_latency(OUT_REG);
    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (!params_legal(DATA_W, DEPTH, ADDR_W)) begin : g_bad_params
        $error("descriptor_memory_dp: DATA_W must be a multiple of 8 and DEPTH <= 2**ADDR_W");
    end

    logic              w_req1;
    logic              w_req2;
    logic              w_grant1;
    logic              w_grant2;
    logic              w_grant;
    port_t             r_last_grant;
    port_t             w_last_grant_nxt;

    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_sel_write;
    logic [NB-1:0]     w_sel_be;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_in_range;
    logic              w_ram_en;
    logic [DATA_W-1:0] w_ram_rdata;
    logic [DATA_W-1:0] w_rd_data;

    rd_tag_t           w_tag_in;
    rd_tag_t           w_tag_out;
    rd_tag_t           r_pipe [LAT];

    assign w_req1 = s1_chipselect & (s1_read | s1_write);
    assign w_req2 = s2_chipselect & (s2_read | s2_write);

    // Round-robin: on contention the port not granted last time wins.
    always_comb begin
        w_grant1         = 1'b0;
        w_grant2         = 1'b0;
        w_last_grant_nxt = r_last_grant;
        if (w_req1 && (!w_req2 || (r_last_grant == PORT_S2))) begin
            w_grant1         = 1'b1;
            w_last_grant_nxt = PORT_S1;
        end else if (w_req2) begin
            w_grant2         = 1'b1;
            w_last_grant_nxt = PORT_S2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= PORT_S2;
        end else begin
            r_last_grant <= w_last_grant_nxt;
        end
    end

    assign w_grant        = w_grant1 | w_grant2;
    assign s1_waitrequest = w_req1 & ~w_grant1;
    assign s2_waitrequest = w_req2 & ~w_grant2;

    assign w_sel_addr  = w_grant2 ? s2_address    : s1_address;
    assign w_sel_write = w_grant2 ? s2_write      : s1_write;
    assign w_sel_be    = w_grant2 ? s2_byteenable : s1_byteenable;
    assign w_sel_wdata = w_grant2 ? s2_writedata  : s1_writedata;

    // Out-of-range accesses never reach the RAM; reads are flagged so they return zero.
    assign w_in_range = ({1'b0, w_sel_addr} < (ADDR_W + 1)'(DEPTH));
    assign w_ram_en   = w_grant & w_in_range;

    dm_ram_be #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .OUT_REG (OUT_REG)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_sel_write),
        .i_be    (w_sel_be),
        .i_addr  (RAM_AW'(w_sel_addr)),
        .i_wdata (w_sel_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        w_tag_in      = '0;
        w_tag_in.v_s1 = w_grant1 & ~s1_write;
        w_tag_in.v_s2 = w_grant2 & ~s2_write;
        w_tag_in.oor  = ~w_in_range;
    end

    // Tag pipeline matches RAM read latency so valids line up with data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(LAT); i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_tag_in;
            for (int i = 1; i < int'(LAT); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_tag_out        = r_pipe[LAT-1];
    assign w_rd_data        = w_tag_out.oor ? '0 : w_ram_rdata;
    assign s1_readdatavalid = w_tag_out.v_s1;
    assign s2_readdatavalid = w_tag_out.v_s2;
    assign s1_readdata      = w_tag_out.v_s1 ? w_rd_data : '0;
    assign s2_readdata      = w_tag_out.v_s2 ? w_rd_data : '0;

endmodule

// File: tb/tb_descriptor_memory_dp.sv
// Bench for descriptor_memory_dp: three instances (default, OUT_REG=1, DEPTH=300) share stimulus.
module tb_descriptor_memory_dp;

    localparam int NDUT = 3;

    typedef struct {
        bit          c1, r1, w1;
        logic [8:0]  a1;
        logic [3:0]  be1;
        logic [31:0] d1;
        bit          c2, r2, w2;
        logic [8:0]  a2;
        logic [3:0]  be2;
        logic [31:0] d2;
        bit          ew1, ew2;
    } vec_t;

    typedef struct {
        int          due;
        bit          port2;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [8:0]  s1_address = '0, s2_address = '0;
    logic        s1_chipselect = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
    logic        s2_chipselect = 1'b0, s2_read = 1'b0, s2_write = 1'b0;
    logic [3:0]  s1_byteenable = '0, s2_byteenable = '0;
    logic [31:0] s1_writedata = '0, s2_writedata = '0;

    logic [31:0] rdata1 [NDUT];
    logic [31:0] rdata2 [NDUT];
    logic        rvalid1 [NDUT];
    logic        rvalid2 [NDUT];
    logic        wait1 [NDUT];
    logic        wait2 [NDUT];

    exp_t        q [NDUT][$];
    logic [31:0] mdl [NDUT][512];
    int          depth_of [NDUT] = '{512, 512, 300};
    int          lat_of   [NDUT] = '{1, 2, 1};
    vec_t        tbl [$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    descriptor_memory_dp #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .OUT_REG(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(rdata1[0]), .s1_readdatavalid(rvalid1[0]), .s1_waitrequest(wait1[0]),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(rdata2[0]), .s2_readdatavalid(rvalid2[0]), .s2_waitrequest(wait2[0])
    );

    descriptor_memory_dp #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .OUT_REG(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(rdata1[1]), .s1_readdatavalid(rvalid1[1]), .s1_waitrequest(wait1[1]),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(rdata2[1]), .s2_readdatavalid(rvalid2[1]), .s2_waitrequest(wait2[1])
    );

    descriptor_memory_dp #(.DATA_W(32), .ADDR_W(9), .DEPTH(300), .OUT_REG(0)) u_dut2 (
        .clk(clk), .reset_n(reset_n),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(rdata1[2]), .s1_readdatavalid(rvalid1[2]), .s1_waitrequest(wait1[2]),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(rdata2[2]), .s2_readdatavalid(rvalid2[2]), .s2_waitrequest(wait2[2])
    );

    function automatic vec_t mk(input bit c1, r1, w1, input logic [8:0] a1,
                                input logic [3:0] be1, input logic [31:0] d1,
                                input bit c2, r2, w2, input logic [8:0] a2,
                                input logic [3:0] be2, input logic [31:0] d2,
                                input bit ew1, ew2);
        vec_t v;
        v.c1 = c1; v.r1 = r1; v.w1 = w1; v.a1 = a1; v.be1 = be1; v.d1 = d1;
        v.c2 = c2; v.r2 = r2; v.w2 = w2; v.a2 = a2; v.be2 = be2; v.d2 = d2;
        v.ew1 = ew1; v.ew2 = ew2;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 0, '0, '0, '0, 0, 0, 0, '0, '0, '0, 0, 0);
    endfunction
    function automatic vec_t wr1(input logic [8:0] a, input logic [3:0] be, input logic [31:0] d);
        return mk(1, 0, 1, a, be, d, 0, 0, 0, '0, '0, '0, 0, 0);
    endfunction
    function automatic vec_t rd1(input logic [8:0] a);
        return mk(1, 1, 0, a, '0, '0, 0, 0, 0, '0, '0, '0, 0, 0);
    endfunction
    function automatic vec_t wr2(input logic [8:0] a, input logic [3:0] be, input logic [31:0] d);
        return mk(0, 0, 0, '0, '0, '0, 1, 0, 1, a, be, d, 0, 0);
    endfunction
    function automatic vec_t rd2(input logic [8:0] a);
        return mk(0, 0, 0, '0, '0, '0, 1, 1, 0, a, '0, '0, 0, 0);
    endfunction
    function automatic vec_t both_rd(input logic [8:0] a1, a2, input bit ew1, ew2);
        return mk(1, 1, 0, a1, '0, '0, 1, 1, 0, a2, '0, '0, ew1, ew2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < NDUT; d++) begin
            bit          e1 = 1'b0;
            bit          e2 = 1'b0;
            logic [31:0] ed1 = '0;
            logic [31:0] ed2 = '0;
            if (q[d].size() > 0 && q[d][0].due == cyc) begin
                if (q[d][0].port2) begin e2 = 1'b1; ed2 = q[d][0].data; end
                else               begin e1 = 1'b1; ed1 = q[d][0].data; end
                void'(q[d].pop_front());
            end
            chk($sformatf("dut%0d.s1_readdatavalid", d), 32'(rvalid1[d]), 32'(e1));
            chk($sformatf("dut%0d.s1_readdata", d), rdata1[d], ed1);
            chk($sformatf("dut%0d.s2_readdatavalid", d), 32'(rvalid2[d]), 32'(e2));
            chk($sformatf("dut%0d.s2_readdata", d), rdata2[d], ed2);
        end
    endtask

    task automatic access(input bit port2, input bit wr, input logic [8:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
        for (int d = 0; d < NDUT; d++) begin
            if (wr) begin
                if (int'(a) < depth_of[d]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) mdl[d][a][b*8 +: 8] = wd[b*8 +: 8];
                    end
                end
            end else begin
                exp_t e;
                e.due   = cyc + lat_of[d];
                e.port2 = port2;
                e.data  = (int'(a) < depth_of[d]) ? mdl[d][a] : 32'h0;
                q[d].push_back(e);
            end
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        check_outputs();
        s1_chipselect = v.c1; s1_read = v.r1; s1_write = v.w1; s1_address = v.a1;
        s1_byteenable = v.be1; s1_writedata = v.d1;
        s2_chipselect = v.c2; s2_read = v.r2; s2_write = v.w2; s2_address = v.a2;
        s2_byteenable = v.be2; s2_writedata = v.d2;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("dut%0d.s1_waitrequest", d), 32'(wait1[d]), 32'(v.ew1));
            chk($sformatf("dut%0d.s2_waitrequest", d), 32'(wait2[d]), 32'(v.ew2));
        end
        if (v.c1 && (v.r1 || v.w1) && !v.ew1) access(1'b0, v.w1, v.a1, v.be1, v.d1);
        if (v.c2 && (v.r2 || v.w2) && !v.ew2) access(1'b1, v.w2, v.a2, v.be2, v.d2);
    endtask

    initial begin
        // Single-port write/read, byte-lane merge, byteenable=0 write, read+write together.
        tbl.push_back(wr1(9'd5, 4'hF, 32'hDEADBEEF));
        tbl.push_back(rd1(9'd5));
        tbl.push_back(wr1(9'd7, 4'hF, 32'hFFFFFFFF));
        tbl.push_back(wr1(9'd7, 4'b0101, 32'h00000000));
        tbl.push_back(rd1(9'd7));
        tbl.push_back(wr2(9'd7, 4'h0, 32'h11111111));
        tbl.push_back(rd2(9'd7));
        tbl.push_back(mk(0, 0, 0, '0, '0, '0, 1, 1, 1, 9'd20, 4'hF, 32'h0BADF00D, 0, 0));
        tbl.push_back(rd2(9'd20));
        for (int i = 0; i < 16; i++) tbl.push_back(wr2(9'(i), 4'hF, 32'hC0DE0000 + 32'(i)));
        // Continuous contention with stalled ports holding their requests; s1 wins first.
        for (int k = 0; k < 8; k++)
            tbl.push_back(both_rd(9'((k + 1) / 2), 9'(8 + k / 2), k[0], !k[0]));
        tbl.push_back(rd1(9'd4));
        tbl.push_back(rd2(9'd1));
        tbl.push_back(rd2(9'd2));
        tbl.push_back(rd2(9'd3));
        // Range check: 400 is outside the DEPTH=300 instance, 144 is 400 mod 256.
        tbl.push_back(wr1(9'd144, 4'hF, 32'hA5A50144));
        tbl.push_back(wr1(9'd400, 4'hF, 32'h12345678));
        tbl.push_back(rd1(9'd400));
        tbl.push_back(rd1(9'd144));
        // Write contention with last grant on s1: s2 wins, s1 stays stalled one cycle.
        tbl.push_back(mk(1, 0, 1, 9'd30, 4'hF, 32'h30303030, 1, 0, 1, 9'd31, 4'hF, 32'h31313131, 1, 0));
        tbl.push_back(wr1(9'd30, 4'hF, 32'h30303030));
        tbl.push_back(rd1(9'd30));
        tbl.push_back(rd2(9'd31));
        for (int i = 0; i < 3; i++) tbl.push_back(idle());

        step(idle());
        step(idle());
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) step(tbl[i]);

        // Reset just after an s1 read is granted: its valid must never appear.
        step(rd1(9'd5));
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        for (int d = 0; d < NDUT; d++) q[d].delete();
        step(idle());
        step(idle());
        @(negedge clk);
        reset_n = 1'b1;
        step(both_rd(9'd5, 9'd7, 1'b0, 1'b1));
        step(rd2(9'd7));
        for (int i = 0; i < 4; i++) step(idle());

        for (int d = 0; d < NDUT; d++)
            chk($sformatf("dut%0d.pending_reads", d), 32'(q[d].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
